seq_run_generator: RTL

- Serial stimulus source for the 4-in-a-row sequence detector.
- Takes a programmed run-length pattern (alternating levels starting from a chosen level) and drives it one bit per clock onto a single serial line.
- In parallel, produces a registered "expected detect" flag, cycle-aligned with a Moore-style detector output. On-board or bench checkers compare the detector output against this flag.
- Sits between the switch/key input layer and the detector FSM.

---
 rtl/seq_run_generator_pkg.sv | 20 ++
 rtl/seq_run_generator_if.sv | 28 ++
 rtl/seq_streak_tracker.sv | 40 ++++
 rtl/seq_run_generator.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_run_generator_pkg.sv
// Shared types and defaults for the run-length serial stimulus generator
// and its streak tracker.
package seq_run_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_RUNS = 8;
    localparam int DEF_LEN_W    = 4;
    localparam int DEF_DET_LEN  = 4;

    // Bits needed to hold a streak count that saturates at det_len.
    function automatic int streak_w(input int det_len);
        return $clog2(det_len + 1);
    endfunction

endpackage

// File: rtl/seq_run_generator_if.sv
// Control and stimulus bundle between the switch/key layer, the generator
// and the detector-side checker.
interface seq_run_generator_if
    import seq_run_generator_pkg::*;
#(
    parameter int NUM_RUNS = DEF_NUM_RUNS,
    parameter int LEN_W    = DEF_LEN_W
);
    logic                      start;
    logic                      first_level;
    logic [NUM_RUNS*LEN_W-1:0] run_lens;
    logic                      loop;
    logic                      stop;
    logic                      out_bit;
    logic                      busy;
    logic                      done;
    logic                      expect_det;

    modport master (
        output start, first_level, run_lens, loop, stop,
        input  out_bit, busy, done, expect_det
    );

    modport slave (
        input  start, first_level, run_lens, loop, stop,
        output out_bit, busy, done, expect_det
    );
endinterface

// File: rtl/seq_streak_tracker.sv
// Counts identical consecutive emitted bits and registers the Moore-aligned
// expected-detect flag; also usable as a reference model on the detector side.
module seq_streak_tracker
    import seq_run_generator_pkg::*;
#(
    parameter int DET_LEN = DEF_DET_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic bit_next,
    input  logic bit_cur,
    output logic expect_det
);
    localparam int            SW  = streak_w(DET_LEN);
    localparam logic [SW-1:0] SAT = SW'(DET_LEN);

    logic [SW-1:0] streak;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak     <= '0;
            expect_det <= 1'b0;
        end else begin
            expect_det <= (streak == SAT);
            if (load) begin
                streak <= SW'(1);
            end else if (step) begin
                if (bit_next != bit_cur) begin
                    streak <= SW'(1);
                end else if (streak != SAT) begin
                    streak <= streak + 1'b1;
                end
            end else begin
                streak <= '0;
            end
        end
    end
endmodule

// File: rtl/seq_run_generator.sv
// Emits a programmed alternating run-length pattern one bit per clock and
// the expected 4-in-a-row detect flag aligned with a Moore detector.
//
// state   | meaning
// IDLE    | waiting for start; out_bit holds its last value
// EMIT    | driving run idx at the current level, cnt = cycle within run
// DONE    | one-cycle done pulse, then back to IDLE
module seq_run_generator
    import seq_run_generator_pkg::*;
#(
    parameter int NUM_RUNS = DEF_NUM_RUNS,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int DET_LEN  = DEF_DET_LEN
) (
    input  logic              clk,
    input  logic              rst,
    seq_run_generator_if.slave bus
);
    localparam int                IDX_W    = $clog2(NUM_RUNS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_RUNS - 1);

    state_t                    state;
    logic [NUM_RUNS*LEN_W-1:0] lens_q;
    logic                      first_q;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_inc;
    logic [LEN_W-1:0]          cnt;
    logic [LEN_W-1:0]          cur_len;
    logic [LEN_W-1:0]          next_len;
    logic                      out_bit_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      run_end;
    logic                      pat_end;
    logic                      go_emit;
    logic                      step;
    logic                      next_bit;

    always_comb begin
        idx_inc  = idx + 1'b1;
        cur_len  = lens_q[idx*LEN_W +: LEN_W];
        next_len = lens_q[idx_inc*LEN_W +: LEN_W];
        run_end  = (cnt == cur_len);
        // A zero-length following slot ends the pattern just like the last slot.
        pat_end  = run_end && ((idx == IDX_LAST) || (next_len == '0));
        go_emit  = (state == ST_IDLE) && bus.start && !bus.stop
                   && (bus.run_lens[LEN_W-1:0] != '0);
        step     = (state == ST_EMIT) && !bus.stop && !(pat_end && !bus.loop);
        next_bit = out_bit_q;
        if (state == ST_IDLE) begin
            next_bit = bus.first_level;
        end else if (pat_end) begin
            next_bit = first_q;
        end else if (run_end) begin
            next_bit = ~out_bit_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            lens_q    <= '0;
            first_q   <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            out_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        lens_q  <= bus.run_lens;
                        first_q <= bus.first_level;
                        if (go_emit) begin
                            state     <= ST_EMIT;
                            busy_q    <= 1'b1;
                            idx       <= '0;
                            cnt       <= LEN_W'(1);
                            out_bit_q <= next_bit;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.stop) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        idx    <= '0;
                        cnt    <= '0;
                    end else if (pat_end && !bus.loop) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        idx    <= '0;
                        cnt    <= '0;
                    end else begin
                        out_bit_q <= next_bit;
                        if (pat_end) begin
                            idx <= '0;
                            cnt <= LEN_W'(1);
                        end else if (run_end) begin
                            idx <= idx_inc;
                            cnt <= LEN_W'(1);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    seq_streak_tracker #(.DET_LEN(DET_LEN)) u_streak (
        .clk        (clk),
        .rst        (rst),
        .load       (go_emit),
        .step       (step),
        .bit_next   (next_bit),
        .bit_cur    (out_bit_q),
        .expect_det (bus.expect_det)
    );

    assign bus.out_bit = out_bit_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
